// File: rtl/odesa_layer_param_if.sv
`default_nettype none
// ============================================================================
// Module  : odesa_layer_param_if
// Brief   : Event / attention / spike bundle of the ODESA feast layer.
// Revision: 1.0 - initial release
// ============================================================================
interface odesa_layer_param_if #(
  parameter int p_n_in  = 4,
  parameter int p_n_neu = 6
);
  logic [p_n_in-1:0]  i_event;
  logic               i_las;
  logic               i_gas;
  logic               i_endof_epochs;
  logic               o_las;
  logic [p_n_neu-1:0] o_spike_out;
  logic               o_busy;

  modport master (
    output i_event, i_las, i_gas, i_endof_epochs,
    input  o_las, o_spike_out, o_busy
  );

  modport slave (
    input  i_event, i_las, i_gas, i_endof_epochs,
    output o_las, o_spike_out, o_busy
  );
endinterface
`default_nettype wire

// File: rtl/odesa_layer_param.sv
`default_nettype none
// ============================================================================
// Module  : odesa_layer_param
// Brief   : ODESA feast layer: time-surface context, sequential neuron scoring,
//           one-hot winner spike and attention-driven online training.
//           Define ODESA_EVT_PEND_EN to queue events arriving while busy.
// Revision: 1.0 - initial release
// ============================================================================
module odesa_layer_param #(
  parameter int p_width    = 9,
  parameter int p_n_in     = 4,
  parameter int p_n_neu    = 6,
  parameter int p_eta      = 3,
  parameter int p_win      = 16,
  parameter int p_thr_init = 65536
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  odesa_layer_param_if.slave bus
);
  localparam int c_aw = 2*p_width + $clog2(p_n_in);
  localparam int c_kw = (p_n_neu > 1) ? $clog2(p_n_neu) : 1;
  localparam int c_cw = $clog2(p_win + 1);
  localparam logic [p_width-1:0] c_cmax     = '1;
  localparam logic [p_width-1:0] c_w_init   = {1'b1, {(p_width-1){1'b0}}};
  localparam logic [c_aw-1:0]    c_thr_init = c_aw'(p_thr_init);
  localparam logic [c_kw-1:0]    c_k_last   = c_kw'(p_n_neu - 1);

  localparam logic [2:0] c_st_idle    = 3'd0;
  localparam logic [2:0] c_st_compute = 3'd1;
  localparam logic [2:0] c_st_fire    = 3'd2;
  localparam logic [2:0] c_st_wait    = 3'd3;
  localparam logic [2:0] c_st_train   = 3'd4;
  localparam logic [2:0] c_st_relax   = 3'd5;

  logic [2:0]         state_q, state_d;
  logic [c_kw-1:0]    k_q, k_d, best_idx_q, best_idx_d;
  logic               best_valid_q, best_valid_d;
  logic [c_aw-1:0]    best_score_q, best_score_d;
  logic [c_cw-1:0]    win_q, win_d;
  logic [p_n_neu-1:0] spike_q, spike_d;
  logic [p_width-1:0] age_q [p_n_in];
  logic [p_width-1:0] age_d [p_n_in];
  logic [p_width-1:0] ctx_q [p_n_in];
  logic [p_width-1:0] ctx_d [p_n_in];
  logic [p_width-1:0] wgt_q [p_n_neu][p_n_in];
  logic [p_width-1:0] wgt_d [p_n_neu][p_n_in];
  logic [c_aw-1:0]    thr_q [p_n_neu];
  logic [c_aw-1:0]    thr_d [p_n_neu];

  logic [c_aw-1:0]         w_score;
  logic                    w_hit, w_start, w_attn, w_gas;
  logic [p_n_in-1:0]       w_force;
  logic signed [p_width+1:0] w_wdiff, w_wnew;
  logic signed [c_aw+1:0]    w_tdiff, w_tnew;
  logic [c_aw-1:0]         w_trelax;

  // Attention is meaningless once training is frozen.
  assign w_attn = (bus.i_las | bus.i_gas) & ~bus.i_endof_epochs;
  assign w_gas  = bus.i_gas & ~bus.i_endof_epochs;

`ifdef ODESA_EVT_PEND_EN
  logic pend_q, pend_d;

  always_comb begin
    pend_d = pend_q | ((state_q != c_st_idle) & (|bus.i_event));
    if (state_q == c_st_idle) pend_d = 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pend_q <= 1'b0;
    else          pend_q <= pend_d;
  end

  assign w_start = pend_q | (|bus.i_event);
  assign w_force = pend_q ? '0 : bus.i_event;
`else
  assign w_start = |bus.i_event;
  assign w_force = bus.i_event;
`endif

  always_comb begin
    for (int i = 0; i < p_n_in; i++) begin
      if (bus.i_event[i])          age_d[i] = '0;
      else if (age_q[i] != c_cmax) age_d[i] = age_q[i] + 1'b1;
      else                         age_d[i] = age_q[i];
    end
  end

  always_comb begin
    logic [2*p_width-1:0] prod;
    prod    = '0;
    w_score = '0;
    for (int i = 0; i < p_n_in; i++) begin
      prod    = ctx_q[i] * wgt_q[k_q][i];
      w_score = w_score + c_aw'(prod);
    end
    w_hit = (w_score >= thr_q[k_q]) && (!best_valid_q || (w_score > best_score_q));
  end

  // Next-state and control counters.
  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    best_idx_d   = best_idx_q;
    best_valid_d = best_valid_q;
    best_score_d = best_score_q;
    win_d        = win_q;
    spike_d      = '0;
    for (int i = 0; i < p_n_in; i++) ctx_d[i] = ctx_q[i];
    case (state_q)
      c_st_idle: begin
        if (w_start) begin
          state_d      = c_st_compute;
          k_d          = '0;
          best_valid_d = 1'b0;
          best_idx_d   = '0;
          best_score_d = '0;
          for (int i = 0; i < p_n_in; i++)
            ctx_d[i] = w_force[i] ? c_cmax : (c_cmax - age_q[i]);
        end
      end
      c_st_compute: begin
        if (w_hit) begin
          best_idx_d   = k_q;
          best_valid_d = 1'b1;
          best_score_d = w_score;
        end
        if (k_q == c_k_last) begin
          state_d = c_st_fire;
          if (best_valid_d) spike_d = p_n_neu'(1) << best_idx_d;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      c_st_fire, c_st_wait: begin
        win_d = (state_q == c_st_fire) ? c_cw'(p_win) : (win_q - 1'b1);
        if (best_valid_q && w_attn) begin
          state_d = c_st_train;
        end else if (!best_valid_q && w_gas) begin
          state_d = c_st_relax;
          k_d     = '0;
        end else if (state_q == c_st_fire) begin
          state_d = c_st_wait;
        end else if (win_q == c_cw'(1)) begin
          state_d = c_st_idle;
        end
      end
      c_st_train: state_d = c_st_idle;
      c_st_relax: begin
        if (k_q == c_k_last) state_d = c_st_idle;
        else                 k_d     = k_q + 1'b1;
      end
      default: state_d = c_st_idle;
    endcase
  end

  // Learning datapath: winner pull toward context, or threshold relaxation.
  always_comb begin
    w_wdiff  = '0;
    w_wnew   = '0;
    w_tdiff  = '0;
    w_tnew   = '0;
    w_trelax = '0;
    for (int n = 0; n < p_n_neu; n++) begin
      thr_d[n] = thr_q[n];
      for (int i = 0; i < p_n_in; i++) wgt_d[n][i] = wgt_q[n][i];
    end
    if (state_q == c_st_train) begin
      for (int i = 0; i < p_n_in; i++) begin
        w_wdiff = $signed({2'b00, ctx_q[i]}) - $signed({2'b00, wgt_q[best_idx_q][i]});
        w_wnew  = $signed({2'b00, wgt_q[best_idx_q][i]}) + (w_wdiff >>> p_eta);
        if (w_wnew[p_width+1])   wgt_d[best_idx_q][i] = '0;
        else if (w_wnew[p_width]) wgt_d[best_idx_q][i] = c_cmax;
        else                      wgt_d[best_idx_q][i] = w_wnew[p_width-1:0];
      end
      w_tdiff = $signed({2'b00, best_score_q}) - $signed({2'b00, thr_q[best_idx_q]});
      w_tnew  = $signed({2'b00, thr_q[best_idx_q]}) + (w_tdiff >>> p_eta);
      if (w_tnew[c_aw+1])    thr_d[best_idx_q] = '0;
      else if (w_tnew[c_aw]) thr_d[best_idx_q] = '1;
      else                   thr_d[best_idx_q] = w_tnew[c_aw-1:0];
    end else if (state_q == c_st_relax) begin
      w_trelax  = thr_q[k_q] - (thr_q[k_q] >> p_eta);
      thr_d[k_q] = (w_trelax == '0) ? c_aw'(1) : w_trelax;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= c_st_idle;
      k_q          <= '0;
      best_idx_q   <= '0;
      best_valid_q <= 1'b0;
      best_score_q <= '0;
      win_q        <= '0;
      spike_q      <= '0;
      for (int i = 0; i < p_n_in; i++) begin
        age_q[i] <= c_cmax;
        ctx_q[i] <= '0;
      end
      for (int n = 0; n < p_n_neu; n++) begin
        thr_q[n] <= c_thr_init;
        for (int i = 0; i < p_n_in; i++) wgt_q[n][i] <= c_w_init;
      end
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      best_idx_q   <= best_idx_d;
      best_valid_q <= best_valid_d;
      best_score_q <= best_score_d;
      win_q        <= win_d;
      spike_q      <= spike_d;
      age_q        <= age_d;
      ctx_q        <= ctx_d;
      wgt_q        <= wgt_d;
      thr_q        <= thr_d;
    end
  end

  always_comb begin
    bus.o_busy      = (state_q != c_st_idle);
    bus.o_las       = (state_q == c_st_train) || ((state_q == c_st_relax) && (k_q == '0));
    bus.o_spike_out = spike_q;
  end
endmodule
`default_nettype wire

// File: tb/tb_odesa_layer_param.sv
`default_nettype none
// ============================================================================
// Module  : tb_odesa_layer_param
// Brief   : Directed self-checking bench for odesa_layer_param.
// Revision: 1.0 - initial release
// ============================================================================
module tb_odesa_layer_param;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  odesa_layer_param_if #(.p_n_in(4), .p_n_neu(6)) bus  ();
  odesa_layer_param_if #(.p_n_in(4), .p_n_neu(6)) bus3 ();

  odesa_layer_param dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
  odesa_layer_param #(.p_thr_init(524288)) dut3 (.i_clk(clk), .i_rst_n(rst_n), .bus(bus3));

  task automatic check(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench in the FIRE cycle (7 cycles after the event cycle).
  task automatic pulse_and_spike(input logic [3:0] ev, input logic [5:0] exp_spk, input string tag);
    bus.i_event = ev;
    step();
    bus.i_event = '0;
    for (int t = 2; t <= 7; t++) begin
      if (t == 7) check({tag, " pre"}, bus.o_spike_out, 0);
      step();
    end
    check({tag, " spike"}, bus.o_spike_out, exp_spk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (bus.o_busy && n < 100) begin
      step();
      n++;
    end
    check({tag, " drain"}, bus.o_busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int las_seen, first_t, second_t, busy25;
    logic [5:0] first_v;
    bus.i_event  = '0; bus.i_las  = 1'b0; bus.i_gas  = 1'b0; bus.i_endof_epochs  = 1'b0;
    bus3.i_event = '0; bus3.i_las = 1'b0; bus3.i_gas = 1'b0; bus3.i_endof_epochs = 1'b0;

    // Reset state
    step(); step();
    check("rst busy", bus.o_busy, 0);
    check("rst spike", bus.o_spike_out, 0);
    check("rst las", bus.o_las, 0);
    check("rst w00", dut.wgt_q[0][0], 256);
    check("rst thr0", dut.thr_q[0], 65536);
    check("rst thr3 dut3", dut3.thr_q[0], 524288);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) step();

    // Scenario 1/2: first spike, then local attention on 3rd WAIT cycle
    pulse_and_spike(4'b0001, 6'b000001, "s1");
    step(); step(); step();
    bus.i_las = 1'b1;
    step();
    bus.i_las = 1'b0;
    check("s2 las train", bus.o_las, 1);
    check("s2 busy train", bus.o_busy, 1);
    step();
    check("s2 las after", bus.o_las, 0);
    check("s2 idle", bus.o_busy, 0);
    check("s2 w00", dut.wgt_q[0][0], 287);
    check("s2 w01", dut.wgt_q[0][1], 224);
    check("s2 w03", dut.wgt_q[0][3], 224);
    check("s2 thr0", dut.thr_q[0], 73696);
    check("s2 w10", dut.wgt_q[1][0], 256);
    check("s2 thr1", dut.thr_q[1], 65536);
    step();
    pulse_and_spike(4'b0001, 6'b000001, "s2 rep");
    drain("s2");
    check("s2 w00 hold", dut.wgt_q[0][0], 287);

    // Scenario 4: learning frozen
    las_seen = 0;
    bus.i_endof_epochs = 1'b1;
    bus.i_event = 4'b0001;
    for (int t = 1; t <= 30; t++) begin
      if (t == 10) bus.i_las = 1'b1;
      step();
      if (t == 1)  bus.i_event = '0;
      if (t == 11) bus.i_las = 1'b0;
      if (bus.o_las) las_seen++;
      if (t == 7)  check("s4 spike", bus.o_spike_out, 6'b000001);
      if (t == 23) check("s4 busy end", bus.o_busy, 1);
      if (t == 24) check("s4 idle", bus.o_busy, 0);
    end
    bus.i_endof_epochs = 1'b0;
    check("s4 las", las_seen, 0);
    check("s4 w00", dut.wgt_q[0][0], 287);
    check("s4 thr0", dut.thr_q[0], 73696);

    // Scenario 5: event on ch1 while waiting
    first_t = 0; second_t = 0; first_v = '0; busy25 = 0;
    bus.i_event = 4'b0001;
    for (int t = 1; t <= 55; t++) begin
      step();
      if (t == 1)  bus.i_event = '0;
      if (t == 10) bus.i_event = 4'b0010;
      if (t == 11) bus.i_event = '0;
      if (t == 25) busy25 = int'(bus.o_busy);
      if (bus.o_spike_out != '0) begin
        if (first_t == 0) begin
          first_t = t;
          first_v = bus.o_spike_out;
        end else if (second_t == 0) begin
          second_t = t;
        end
      end
    end
    check("s5 first t", first_t, 7);
    check("s5 first v", first_v, 6'b000001);
`ifdef ODESA_EVT_PEND_EN
    check("s5 second t", second_t, 31);
    check("s5 busy25", busy25, 1);
`else
    check("s5 second t", second_t, 0);
    check("s5 busy25", busy25, 0);
`endif
    drain("s5");

    // Scenario 3: unreachable thresholds, global attention relaxes
    bus3.i_event = 4'b0001;
    step();
    bus3.i_event = '0;
    for (int t = 2; t <= 7; t++) step();
    check("s3 no spike", bus3.o_spike_out, 0);
    bus3.i_gas = 1'b1;
    step();
    bus3.i_gas = 1'b0;
    check("s3 las", bus3.o_las, 1);
    step();
    check("s3 las once", bus3.o_las, 0);
    step(); step(); step(); step();
    check("s3 busy t13", bus3.o_busy, 1);
    step();
    check("s3 idle t14", bus3.o_busy, 0);
    check("s3 thr0", dut3.thr_q[0], 458752);
    check("s3 thr3", dut3.thr_q[3], 458752);
    check("s3 thr5", dut3.thr_q[5], 458752);

    // Scenario 6a: reset during COMPUTE
    bus.i_event = 4'b0001;
    step();
    bus.i_event = '0;
    step(); step();
    check("s6a busy pre", bus.o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("s6a busy", bus.o_busy, 0);
    check("s6a spike", bus.o_spike_out, 0);
    check("s6a las", bus.o_las, 0);
    check("s6a w00", dut.wgt_q[0][0], 256);
    check("s6a thr0", dut.thr_q[0], 65536);
    check("s6a dut3 thr0", dut3.thr_q[0], 524288);
    @(negedge clk) rst_n = 1'b1;
    step(); step();

    // Scenario 6b: reset during TRAIN
    pulse_and_spike(4'b0001, 6'b000001, "s6b");
    bus.i_las = 1'b1;
    step();
    bus.i_las = 1'b0;
    check("s6b las train", bus.o_las, 1);
    rst_n = 1'b0;
    #1;
    check("s6b las", bus.o_las, 0);
    check("s6b busy", bus.o_busy, 0);
    step();
    @(negedge clk) rst_n = 1'b1;
    step();
    check("s6b w00", dut.wgt_q[0][0], 256);
    check("s6b thr0", dut.thr_q[0], 65536);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
`default_nettype wire
